// File: rtl/teclado_atm.sv
// teclado_atm: keypad front-end for the ATM controller.
// Synchronizes and debounces a raw keypad, turns each accepted press into a
// single key event, and either forwards PIN digits or accumulates a decimal
// amount that is committed on ENTER.
module teclado_atm #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITOS     = 9
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        modo_monto,
  input  logic        tecla_activa,
  input  logic [3:0]  tecla_codigo,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        entrada_error
);

  typedef enum logic [1:0] {
    S_REPOSO,
    S_FILTRO_PRESION,
    S_PRESIONADA,
    S_FILTRO_LIBERA
  } estado_t;

  localparam logic [16:0] DEB  = 17'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  MAXD = 4'(MAX_DIGITOS);

  // Two-flop synchronizers for the asynchronous keypad lines
  logic       r_act_m, r_act_s;
  logic [3:0] r_cod_m, r_cod_s;

  // Debounce state
  estado_t     r_estado, w_estado_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [3:0]  r_cod, w_cod_next;
  logic [16:0] w_cnt_inc;
  logic        w_evento;

  // Event decode / accumulator state
  logic        r_modo_prev;
  logic [31:0] r_acc;
  logic [3:0]  r_cuenta;
  logic [3:0]  r_digito;
  logic        r_dig_stb;
  logic [31:0] r_monto;
  logic        r_monto_stb;
  logic        r_err;

  logic [31:0] w_acc_x10, w_acc_dig;
  logic        w_es_digito, w_es_enter, w_es_borrar;

  // Bring tecla_activa and tecla_codigo into the CLK domain
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_act_m <= 1'b0;
      r_act_s <= 1'b0;
      r_cod_m <= 4'd0;
      r_cod_s <= 4'd0;
    end else begin
      r_act_m <= tecla_activa;
      r_act_s <= r_act_m;
      r_cod_m <= tecla_codigo;
      r_cod_s <= r_cod_m;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_estado <= S_REPOSO;
      r_cnt    <= 16'd0;
      r_cod    <= 4'd0;
    end else begin
      r_estado <= w_estado_next;
      r_cnt    <= w_cnt_next;
      r_cod    <= w_cod_next;
    end
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  // Debounce FSM next state; evento fires on the cycle the press count is reached
  always_comb begin
    w_estado_next = r_estado;
    w_cnt_next    = r_cnt;
    w_cod_next    = r_cod;
    w_evento      = 1'b0;
    case (r_estado)
      S_REPOSO: begin
        if (r_act_s) begin
          w_cod_next = r_cod_s;
          w_cnt_next = 16'd1;
          // A one-cycle filter is already satisfied by the first sample
          if (DEB <= 17'd1) begin
            w_evento      = 1'b1;
            w_estado_next = S_PRESIONADA;
          end else begin
            w_estado_next = S_FILTRO_PRESION;
          end
        end
      end
      S_FILTRO_PRESION: begin
        if (!r_act_s || (r_cod_s != r_cod)) begin
          w_cnt_next    = 16'd0;
          w_estado_next = S_REPOSO;
        end else begin
          w_cnt_next = w_cnt_inc[15:0];
          if (w_cnt_inc >= DEB) begin
            w_evento      = 1'b1;
            w_estado_next = S_PRESIONADA;
          end
        end
      end
      S_PRESIONADA: begin
        if (!r_act_s) begin
          w_cnt_next    = 16'd1;
          w_estado_next = S_FILTRO_LIBERA;
        end
      end
      S_FILTRO_LIBERA: begin
        if (r_act_s) begin
          w_estado_next = S_PRESIONADA;
        end else begin
          w_cnt_next = w_cnt_inc[15:0];
          if (w_cnt_inc >= DEB) begin
            w_cnt_next    = 16'd0;
            w_estado_next = S_REPOSO;
          end
        end
      end
      default: begin
        w_cnt_next    = 16'd0;
        w_estado_next = S_REPOSO;
      end
    endcase
  end

  // Key classification and acc*10 + d using shifts only
  assign w_es_digito = (w_cod_next <= 4'd9);
  assign w_es_enter  = (w_cod_next == 4'hA);
  assign w_es_borrar = (w_cod_next == 4'hB);
  assign w_acc_x10   = (r_acc << 3) + (r_acc << 1);
  assign w_acc_dig   = w_acc_x10 + {28'd0, w_cod_next};

  // Decode each key event into registered strobes and the amount accumulator
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_modo_prev <= 1'b0;
      r_acc       <= 32'd0;
      r_cuenta    <= 4'd0;
      r_digito    <= 4'd0;
      r_dig_stb   <= 1'b0;
      r_monto     <= 32'd0;
      r_monto_stb <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_dig_stb   <= 1'b0;
      r_monto_stb <= 1'b0;
      r_err       <= 1'b0;
      r_modo_prev <= modo_monto;
      if (w_evento) begin
        if (!modo_monto) begin
          if (w_es_digito) begin
            r_digito  <= w_cod_next;
            r_dig_stb <= 1'b1;
          end else if (!w_es_enter && !w_es_borrar) begin
            r_err <= 1'b1;
          end
        end else begin
          if (w_es_digito) begin
            if (r_cuenta < MAXD) begin
              r_acc    <= w_acc_dig;
              r_cuenta <= r_cuenta + 4'd1;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_es_enter) begin
            if (r_cuenta != 4'd0) begin
              r_monto     <= r_acc;
              r_monto_stb <= 1'b1;
              r_acc       <= 32'd0;
              r_cuenta    <= 4'd0;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_es_borrar) begin
            r_acc    <= 32'd0;
            r_cuenta <= 4'd0;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
      // A mode switch abandons any partially typed amount
      if (modo_monto != r_modo_prev) begin
        r_acc    <= 32'd0;
        r_cuenta <= 4'd0;
      end
    end
  end

  assign digito        = r_digito;
  assign digito_stb    = r_dig_stb;
  assign monto         = r_monto;
  assign monto_stb     = r_monto_stb;
  assign entrada_error = r_err;

endmodule

// File: tb/tb_teclado_atm.sv
// Testbench for teclado_atm: scenario tasks driving keypad presses, checked
// against a key-level reference model of the PIN/amount entry rules.
module tb_teclado_atm;

  localparam int D    = 4;
  localparam int MAXD = 9;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        modo_monto = 1'b0;
  logic        tecla_activa = 1'b0;
  logic [3:0]  tecla_codigo = 4'd0;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        entrada_error;

  teclado_atm #(.DEBOUNCE_CYCLES(D), .MAX_DIGITOS(MAXD)) dut (
    .CLK(CLK), .RESET(RESET), .modo_monto(modo_monto),
    .tecla_activa(tecla_activa), .tecla_codigo(tecla_codigo),
    .digito(digito), .digito_stb(digito_stb), .monto(monto),
    .monto_stb(monto_stb), .entrada_error(entrada_error)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Observed strobes and model expectations
  logic [3:0]  q_dig[$];
  logic [3:0]  e_dig[$];
  logic [31:0] q_monto[$];
  logic [31:0] e_monto[$];
  int          n_err = 0;
  int          e_err = 0;
  int          n_viol = 0;
  longint      m_acc = 0;
  int          m_cnt = 0;
  logic [3:0]  e_last_dig = 4'd0;
  logic [31:0] e_last_monto = 32'd0;

  // Record every strobe observed while out of reset
  always @(negedge CLK) begin
    if (RESET) begin
      if (digito_stb) q_dig.push_back(digito);
      if (monto_stb) q_monto.push_back(monto);
      if (entrada_error) n_err++;
      if (int'(digito_stb) + int'(monto_stb) + int'(entrada_error) > 1) n_viol++;
    end
  end

  // Reference: effect of one accepted key under the current mode
  task automatic model_event(input logic [3:0] code);
    if (!modo_monto) begin
      if (code <= 9) begin
        e_dig.push_back(code);
        e_last_dig = code;
      end else if (code >= 12) begin
        e_err++;
      end
    end else begin
      if (code <= 9) begin
        if (m_cnt < MAXD) begin
          m_acc = m_acc * 10 + code;
          m_cnt++;
        end else e_err++;
      end else if (code == 10) begin
        if (m_cnt > 0) begin
          e_monto.push_back(32'(m_acc));
          e_last_monto = 32'(m_acc);
          m_acc = 0;
          m_cnt = 0;
        end else e_err++;
      end else if (code == 11) begin
        m_acc = 0;
        m_cnt = 0;
      end else e_err++;
    end
  endtask

  function automatic int sb_diff();
    int d = 0;
    if (q_dig.size() != e_dig.size()) d++;
    else foreach (q_dig[i]) if (q_dig[i] !== e_dig[i]) d++;
    if (q_monto.size() != e_monto.size()) d++;
    else foreach (q_monto[i]) if (q_monto[i] !== e_monto[i]) d++;
    if (n_err != e_err) d++;
    return d;
  endfunction

  task automatic flush();
    q_dig.delete(); e_dig.delete();
    q_monto.delete(); e_monto.delete();
    n_err = 0; e_err = 0;
  endtask

  task automatic set_mode(input logic m);
    @(negedge CLK);
    if (m != modo_monto) begin
      m_acc = 0;
      m_cnt = 0;
    end
    modo_monto = m;
    repeat (2) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    @(negedge CLK);
    tecla_codigo = code;
    tecla_activa = 1'b1;
    repeat (hold) @(negedge CLK);
    tecla_activa = 1'b0;
    repeat (gap) @(negedge CLK);
    model_event(code);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    n_total++;
    if (digito !== 4'd0 || digito_stb !== 1'b0 || monto !== 32'd0 ||
        monto_stb !== 1'b0 || entrada_error !== 1'b0)
      $display("FAIL reset_state: got dig=%0d dstb=%0b monto=%0d mstb=%0b err=%0b, want all 0",
               digito, digito_stb, monto, monto_stb, entrada_error);
    else n_pass++;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    $display("test_reset done");
  endtask

  task automatic test_pin_latency();
    logic [3:0] code;
    set_mode(1'b0);
    for (int c = 1; c <= 4; c++) begin
      code = 4'(c);
      @(negedge CLK);
      tecla_codigo = code;
      tecla_activa = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge CLK);
        #1;
        if (k == D + 1) begin
          n_total++;
          if (digito_stb !== 1'b0)
            $display("FAIL early_strobe key %0d: got stb=%0b want 0", c, digito_stb);
          else n_pass++;
        end
        if (k == D + 2) begin
          n_total++;
          if (digito_stb !== 1'b1 || digito !== code)
            $display("FAIL latency key %0d: got stb=%0b dig=%0d want stb=1 dig=%0d",
                     c, digito_stb, digito, code);
          else n_pass++;
        end
      end
      @(negedge CLK);
      tecla_activa = 1'b0;
      repeat (10) @(negedge CLK);
      model_event(code);
      $display("pin key %0d pressed", c);
    end
    n_total++;
    if (sb_diff() != 0)
      $display("FAIL pin_seq: got %0d digits %0d errs, want %0d digits %0d errs",
               q_dig.size(), n_err, e_dig.size(), e_err);
    else n_pass++;
    flush();
  endtask

  task automatic test_glitch();
    int pat[5] = '{6, 2, 6, 2, 4};
    @(negedge CLK);
    tecla_codigo = 4'd7;
    tecla_activa = 1'b1;
    repeat (3) @(negedge CLK);
    tecla_activa = 1'b0;
    repeat (10) @(negedge CLK);
    n_total++;
    if (q_dig.size() != 0 || n_err != 0)
      $display("FAIL glitch: got %0d strobes want 0", q_dig.size() + n_err);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tecla_activa = (i % 2 == 0);
      repeat (pat[i]) @(negedge CLK);
    end
    tecla_activa = 1'b0;
    repeat (12) @(negedge CLK);
    model_event(4'd7);
    n_total++;
    if (sb_diff() != 0 || digito !== 4'd7)
      $display("FAIL bounce: got %0d digits last=%0d want 1 digit 7", q_dig.size(), digito);
    else n_pass++;
    flush();
    $display("test_glitch done");
  endtask

  task automatic test_amount();
    logic [3:0] keys[5] = '{4'd2, 4'd5, 4'd0, 4'd0, 4'hA};
    set_mode(1'b1);
    foreach (keys[i]) press(keys[i], D + 2, D + 3);
    n_total++;
    if (monto !== 32'd2500 || q_monto.size() != 1 || digito_stb !== 1'b0)
      $display("FAIL amount_2500: got monto=%0d strobes=%0d want 2500 and 1", monto, q_monto.size());
    else n_pass++;
    press(4'hA, D + 2, D + 3);
    n_total++;
    if (sb_diff() != 0 || monto !== e_last_monto)
      $display("FAIL enter_empty: got monto=%0d errs=%0d want monto=%0d errs=%0d",
               monto, n_err, e_last_monto, e_err);
    else n_pass++;
    flush();
    $display("test_amount done");
  endtask

  task automatic test_max_digits();
    for (int i = 0; i < 10; i++) press(4'd9, D + 2, D + 3);
    press(4'hA, D + 2, D + 3);
    n_total++;
    if (sb_diff() != 0 || monto !== 32'd999999999 || n_err != 1)
      $display("FAIL max_digits: got monto=%0d errs=%0d want 999999999 and 1", monto, n_err);
    else n_pass++;
    flush();
    $display("test_max_digits done");
  endtask

  task automatic test_borrar_mode();
    logic [3:0] keys[4] = '{4'd7, 4'hB, 4'd3, 4'hA};
    foreach (keys[i]) press(keys[i], D + 2, D + 3);
    n_total++;
    if (monto !== 32'd3 || sb_diff() != 0)
      $display("FAIL borrar: got monto=%0d want 3", monto);
    else n_pass++;
    press(4'd4, D + 2, D + 3);
    set_mode(1'b0);
    set_mode(1'b1);
    press(4'hA, D + 2, D + 3);
    n_total++;
    if (sb_diff() != 0 || n_err != 1 || monto !== 32'd3)
      $display("FAIL mode_clear: got errs=%0d monto=%0d want errs=1 monto=3", n_err, monto);
    else n_pass++;
    flush();
    $display("test_borrar_mode done");
  endtask

  task automatic test_reset_mid_hold();
    set_mode(1'b0);
    @(negedge CLK);
    tecla_codigo = 4'd5;
    tecla_activa = 1'b1;
    repeat (D + 6) @(negedge CLK);
    model_event(4'd5);
    n_total++;
    if (sb_diff() != 0)
      $display("FAIL pre_reset: got %0d digits want %0d", q_dig.size(), e_dig.size());
    else n_pass++;
    flush();
    RESET = 1'b0;
    #1;
    n_total++;
    if (digito !== 4'd0 || digito_stb !== 1'b0 || monto !== 32'd0 ||
        monto_stb !== 1'b0 || entrada_error !== 1'b0)
      $display("FAIL mid_reset: got dig=%0d monto=%0d want 0 0", digito, monto);
    else n_pass++;
    m_acc = 0; m_cnt = 0; e_last_dig = 4'd0; e_last_monto = 32'd0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    for (int k = 1; k <= D + 2; k++) begin
      @(posedge CLK);
      #1;
      if (k == D + 1) begin
        n_total++;
        if (digito_stb !== 1'b0 || digito !== 4'd0)
          $display("FAIL post_reset_early: got stb=%0b dig=%0d want 0 0", digito_stb, digito);
        else n_pass++;
      end
    end
    n_total++;
    if (digito_stb !== 1'b1 || digito !== 4'd5)
      $display("FAIL post_reset_press: got stb=%0b dig=%0d want 1 5", digito_stb, digito);
    else n_pass++;
    @(negedge CLK);
    tecla_activa = 1'b0;
    repeat (D + 4) @(negedge CLK);
    model_event(4'd5);
    n_total++;
    if (sb_diff() != 0)
      $display("FAIL post_reset_count: got %0d digits want 1", q_dig.size());
    else n_pass++;
    flush();
    $display("test_reset_mid_hold done");
  endtask

  task automatic test_random();
    logic [3:0] code;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) set_mode(~modo_monto);
      if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(10, 15));
      else code = 4'($urandom_range(0, 9));
      press(code, $urandom_range(D + 1, D + 5), $urandom_range(D + 2, D + 6));
      $display("rand key %0d code=%0h mode=%0b", i, code, modo_monto);
      if (i % 15 == 14) begin
        n_total++;
        if (sb_diff() != 0 || digito !== e_last_dig || monto !== e_last_monto)
          $display("FAIL random_%0d: got dig=%0d monto=%0d errs=%0d want dig=%0d monto=%0d errs=%0d",
                   i, digito, monto, n_err, e_last_dig, e_last_monto, e_err);
        else n_pass++;
        flush();
      end
    end
  endtask

  initial begin
    test_reset();
    test_pin_latency();
    test_glitch();
    test_amount();
    test_max_digits();
    test_borrar_mode();
    test_reset_mid_hold();
    test_random();
    n_total++;
    if (n_viol != 0)
      $display("FAIL onehot: got %0d cycles with multiple strobes want 0", n_viol);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
